// File: rtl/demux_ctrl_pkg.sv
// Shared types and helpers for the demux routing controller.
// State encoding, destination sizing and strobe decode.
package demux_ctrl_pkg;

   localparam int DEST_W = 3;
   localparam int NDEST  = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      LAST,
      DONE
   } state_t;

   function automatic logic [NDEST-1:0] onehot8(
      input logic [DEST_W-1:0] dest
   );
      logic [NDEST-1:0] v;
      v       = '0;
      v[dest] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/demux_route_ctrl_beat_counter.sv
// Loadable down-counter with zero flag.
// Holds at zero rather than wrapping.
module beat_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   assign zero = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/demux_route_ctrl.sv
// Sequencing controller for a 1-to-8 enabled demux.
// Streams payload beats to one destination per command.
module demux_route_ctrl
   import demux_ctrl_pkg::*;
#(
   parameter int LEN_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DEST_W-1:0] cmd_dest,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              din,
   input  logic [NDEST-1:0]  dst_ready,
   input  logic              abort,
   output logic [DEST_W-1:0] S,
   output logic              En,
   output logic              i,
   output logic [NDEST-1:0]  strobe,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   state_t           state;
   state_t           state_nx;
   logic             acc;
   logic             load;
   logic             zero;
   logic             en_nx;
   logic [NDEST-1:0] stb_nx;
   logic             done_nx;
   logic             abt_nx;

   beat_counter #(
      .W(LEN_W)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .load_val(cmd_len),
      .dec     (acc),
      .zero    (zero)
   );

   assign busy = (state != IDLE);

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      din_ready = 1'b0;
      acc       = 1'b0;
      load      = 1'b0;
      en_nx     = 1'b0;
      stb_nx    = '0;
      done_nx   = 1'b0;
      abt_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load     = 1'b1;
               state_nx = SETUP;
            end
         end
         SETUP: begin
            if (abort) begin
               abt_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = XFER;
            end
         end
         XFER: begin
            din_ready = dst_ready[S] & ~abort;
            acc       = din_valid & din_ready;
            if (abort) begin
               abt_nx   = 1'b1;
               state_nx = IDLE;
            end else if (acc) begin
               en_nx  = 1'b1;
               stb_nx = onehot8(S);
               if (zero) state_nx = LAST;
            end
         end
         LAST: begin
            done_nx  = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         S       <= '0;
         En      <= 1'b0;
         i       <= 1'b0;
         strobe  <= '0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state   <= state_nx;
         En      <= en_nx;
         strobe  <= stb_nx;
         done    <= done_nx;
         aborted <= abt_nx;
         if (load) S <= cmd_dest;
         // i only matters while En is high
         if (acc) i <= din;
      end
   end

endmodule
